// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with IF/ID register, a one-entry holding buffer
// for decode stalls, and PCSel redirect that drops in-flight fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        PCSel,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [6:0]  if_opcode
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic [31:0] target;
  logic        fire;
  logic        rsp_in;
  logic        load_rsp;
  logic        load_hold;
  logic        park;

  assign fire          = imem_req_valid && imem_req_ready;
  assign rsp_in        = (state == S_WAIT) && imem_rsp_valid;
  assign target        = redirect_target & 32'hFFFF_FFFC;
  assign imem_req_addr = pc;
  assign if_opcode     = if_inst[6:0];

  always_comb begin
    state_nxt = state;
    load_rsp  = 1'b0;
    load_hold = 1'b0;
    park      = 1'b0;
    if (PCSel) begin
      // Any request still owed a response must be drained in DROP.
      unique case (state)
        S_REQ:  state_nxt = fire ? S_DROP : S_REQ;
        S_WAIT: state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
        S_HOLD: state_nxt = S_REQ;
        S_DROP: state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (fire) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (!if_valid || !stall) begin
              load_rsp  = 1'b1;
              state_nxt = S_REQ;
            end else begin
              park      = 1'b1;
              state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load_hold = 1'b1;
            state_nxt = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state_nxt = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_REQ;
      imem_req_valid <= 1'b0;
      pc             <= RESET_PC;
      hold_pc        <= RESET_PC;
      hold_inst      <= NOP_INST;
      if_valid       <= 1'b0;
      if_pc          <= RESET_PC;
      if_inst        <= NOP_INST;
    end else begin
      state          <= state_nxt;
      imem_req_valid <= (state_nxt == S_REQ);
      if (PCSel) begin
        pc       <= target;
        if_valid <= 1'b0;
        if_inst  <= NOP_INST;
      end else begin
        if (rsp_in) pc <= pc + 32'd4;
        if (park) begin
          hold_pc   <= pc;
          hold_inst <= imem_rsp_data;
        end
        if (load_rsp) begin
          if_valid <= 1'b1;
          if_pc    <= pc;
          if_inst  <= imem_rsp_data;
        end else if (load_hold) begin
          if_valid <= 1'b1;
          if_pc    <= hold_pc;
          if_inst  <= hold_inst;
        end else if (!stall) begin
          if_valid <= 1'b0;
          if_inst  <= NOP_INST;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: memory model + scoreboard of the fetch stream
// in program order, with directed corner cases and random traffic.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        stall = 1'b0;
  logic        PCSel = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [6:0]  if_opcode;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .PCSel          (PCSel),
    .redirect_target(redirect_target),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_opcode      (if_opcode)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  item_t       exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] model_pc = 32'h0;
  logic [31:0] out_addr = 32'h0;
  logic [31:0] out_pc = 32'h0;
  bit          outst = 1'b0;
  bit          doomed = 1'b0;
  int          cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock cycle: memory behaviour plus reference fetch-stream model.
  task automatic step(input bit rdy, input bit stl, input bit sel,
                      input logic [31:0] tgt, input int lat);
    @(negedge clk);
    if (outst) chk("one_outstanding", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b0;
    if (outst) begin
      if (cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(out_addr);
      end else begin
        cnt--;
      end
    end
    imem_req_ready  = rdy;
    stall           = stl;
    PCSel           = sel;
    redirect_target = tgt;
    if (sel) begin
      exp_q.delete();
      doomed = outst;
    end
    if (imem_rsp_valid) begin
      if (!doomed) exp_q.push_back('{pc: out_pc, inst: mem_word(out_pc)});
      outst  = 1'b0;
      doomed = 1'b0;
    end
    if (imem_req_valid && rdy) begin
      n_acc++;
      outst    = 1'b1;
      cnt      = lat;
      out_addr = imem_req_addr;
      out_pc   = model_pc;
      doomed   = sel;
      addr_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
    if (sel) model_pc = {tgt[31:2], 2'b00};
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    stall          = 1'b0;
    PCSel          = 1'b0;
    outst          = 1'b0;
    doomed         = 1'b0;
    model_pc       = 32'h0;
    exp_q.delete();
    addr_q.delete();
    repeat (n) @(negedge clk);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_inst", if_inst, NOP);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_opcode", {25'b0, if_opcode}, 32'h13);
    rst_n = 1'b1;
  endtask

  task automatic wait_accept(input string name, output logic [31:0] a);
    bit got;
    got = 1'b0;
    a   = 32'hx;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1, 0, 0, 32'h0, 1);
      if (imem_req_valid) begin
        got = 1'b1;
        a   = imem_req_addr;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no request within 10 cycles", name);
    end
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  bit          stab = 1'b0;
  logic [31:0] stab_addr = 32'h0;
  initial begin
    item_t       it;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        stab = 1'b0;
      end else begin
        if (stab) begin
          chk("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
          chk("req_hold_addr", imem_req_addr, stab_addr);
        end
        stab      = imem_req_valid && !imem_req_ready && !PCSel;
        stab_addr = imem_req_addr;
        if (imem_req_valid && imem_req_ready) begin
          if (addr_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_addr: unexpected request %h", imem_req_addr);
          end else begin
            ea = addr_q.pop_front();
            chk("req_addr", imem_req_addr, ea);
          end
        end
        if (if_valid && !stall && !PCSel) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL if_stream: unexpected pc %h inst %h",
                     if_pc, if_inst);
          end else begin
            it = exp_q.pop_front();
            chk("if_pc", if_pc, it.pc);
            chk("if_inst", if_inst, it.inst);
            chk("if_opcode", {25'b0, if_opcode}, {25'b0, it.inst[6:0]});
          end
        end else if (!if_valid) begin
          chk("empty_inst", if_inst, NOP);
          chk("empty_opcode", {25'b0, if_opcode}, 32'h13);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          c0;
    int          c1;
    int          acc0;
    int          reqs;
    int          seen;
    bit          got;
    logic [31:0] a;
    logic [31:0] a0;
    logic [31:0] tg;

    do_reset(2);

    // Always ready, latency 1: request every 2 cycles, valid 2 after.
    c0   = -1;
    c1   = -1;
    acc0 = n_acc;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 32'h0, 1);
      if (c0 < 0 && imem_req_valid) c0 = i;
      if (c1 < 0 && if_valid) c1 = i;
    end
    chk("first_valid_lat", c1 - c0, 32'd2);
    chk("throughput", n_acc - acc0, 32'd6);

    // Decode stall parks a response in the holding buffer.
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    a0 = model_pc;
    step(1, 1, 0, 32'h0, 1);
    step(1, 1, 0, 32'h0, 1);
    step(1, 1, 0, 32'h0, 1);
    chk("stall_first_pc", if_pc, a0);
    step(1, 1, 0, 32'h0, 1);
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 32'h0, 1);
      if (imem_req_valid) reqs++;
      chk("stall_hold_pc", if_pc, a0);
      chk("stall_hold_inst", if_inst, mem_word(a0));
    end
    chk("stall_no_req", reqs, 32'd0);
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    chk("unpark_valid", {31'b0, if_valid}, 32'd1);
    chk("unpark_pc", if_pc, a0 + 32'd4);
    chk("unpark_inst", if_inst, mem_word(a0 + 32'd4));
    chk("unpark_req", {31'b0, imem_req_valid}, 32'd1);
    chk("unpark_addr", imem_req_addr, a0 + 32'd8);

    // Redirect while WAITing: orphan dropped, then fetch from 0x100.
    step(1, 0, 0, 32'h0, 3);
    step(0, 0, 1, 32'h0000_0103, 1);
    got  = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(0, 0, 0, 32'h0, 1);
      if (if_valid) seen++;
      if (imem_req_valid) got = 1'b1;
    end
    chk("drop_req_seen", {31'b0, got}, 32'd1);
    chk("drop_addr", imem_req_addr, 32'h0000_0100);
    chk("drop_no_valid", seen, 32'd0);

    // Redirect together with a response: no DROP cycle.
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h0000_0200, 1);
    step(0, 0, 0, 32'h0, 1);
    chk("same_cyc_req", {31'b0, imem_req_valid}, 32'd1);
    chk("same_cyc_addr", imem_req_addr, 32'h0000_0200);
    chk("same_cyc_valid", {31'b0, if_valid}, 32'd0);

    // Ready low for three cycles: one stable request, one accept.
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 1);
      chk("ready_low_addr", imem_req_addr, 32'h0000_0200);
    end
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    chk("single_accept", n_acc - acc0, 32'd1);

    // PC wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFE, 1);
    wait_accept("wrap_a", a);
    chk("wrap_top", a, 32'hFFFF_FFFC);
    wait_accept("wrap_b", a);
    chk("wrap_zero", a, 32'h0);

    // Reset in the middle of a WAIT.
    step(0, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 3);
    step(0, 0, 0, 32'h0, 3);
    do_reset(1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      tg = ($urandom_range(0, 3) == 0) ?
           (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 99) < 4, tg, $urandom_range(1, 3));
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 32'h0, 1);
    chk("drain_stream", exp_q.size(), 32'd0);
    chk("drain_addr", addr_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage with IF/ID pipeline register, sitting directly upstream of the main decoder. It holds the PC, issues one instruction-memory request at a time over a valid/ready handshake, and captures the returned word into the IF/ID register, where `if_opcode` (bits [6:0]) drives the decoder. It honours decode-stage stalls through a one-entry holding buffer and redirects on `PCSel` from execute, discarding any in-flight fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `NOP_INST`, 32'h0000_0013, instruction word presented when the IF/ID register is empty (addi x0,x0,0)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  fetch address (word aligned)
- `imem_rsp_valid`  in  1  response valid (exactly one per accepted request, ≥1 cycle after accept)
- `imem_rsp_data`  in  32  instruction word
- `stall`  in  1  decode cannot take a new instruction; hold IF/ID
- `PCSel`  in  1  redirect request from execute (branch/jal taken)
- `redirect_target`  in  32  new PC; bits [1:0] ignored, forced to 0
- `if_valid`  out  1  IF/ID holds a live instruction
- `if_pc`  out  32  PC of `if_inst`
- `if_inst`  out  32  instruction word
- `if_opcode`  out  7  `if_inst[6:0]`, combinational

## Operation
- States: REQ, WAIT, HOLD, DROP. Reset state REQ.
- Reset (`rst_n`=0 at a rising edge): pc=RESET_PC, state=REQ, `if_valid`=0, `if_inst`=NOP_INST, `if_pc`=RESET_PC, holding buffer empty. `imem_req_valid`=0 while `rst_n`=0; 1 from the first cycle after release. Reset mid-transaction discards any pending response; memory must also be reset.
- REQ: `imem_req_valid`=1, `imem_req_addr`=pc. On `imem_req_ready`=1, go to WAIT. Addr stays stable while waiting for ready.
- WAIT: `imem_req_valid`=0. On `imem_rsp_valid`:
  - If IF/ID free (`if_valid`=0 or `stall`=0): load `if_inst`=data, `if_pc`=pc, `if_valid`=1. Then pc=pc+4 and go to REQ.
  - Else: store data and pc in the holding buffer, pc=pc+4, and go to HOLD.
- HOLD: no request. When `stall`=0, move the buffer into IF/ID (`if_valid`=1) and go to REQ.
- DROP: no request. Wait for the orphaned response, discard it, then go to REQ.
- IF/ID consumption: if `stall`=0 and no new load this cycle, `if_valid` goes to 0 next cycle and `if_inst` goes to NOP_INST. If `stall`=1, all `if_*` hold.
- Redirect (`PCSel`=1) takes priority over stall and response. It applies in that cycle:
  - pc={target[31:2],2'b00}; `if_valid`=0, `if_inst`=NOP_INST; the holding buffer is cleared.
  - Next state:
    - DROP if a request is outstanding: state WAIT without `imem_rsp_valid` this cycle, or REQ with ready=1 this cycle.
    - REQ if in WAIT with `imem_rsp_valid`=1 this cycle; that response is discarded.
    - REQ from HOLD, DROP-with-response, or REQ without handshake.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- At most one outstanding request.
- Request accepted at edge N, response at edge N+k (k≥1). `if_valid` is high from edge N+k onward (registered). Next request is asserted after edge N+k.
- Peak throughput: one instruction per 2 cycles with k=1.
- Redirect at edge R: `if_valid`=0 after R. The new target's request is asserted after R, or after the orphan response if in DROP.
- `if_opcode` is valid whenever `if_valid`=1. When `if_valid`=0 it equals 7'b0010011 (NOP), so the decoder sees a non-writing, harmless I-type.

## Test plan
- Reset release, memory always ready, 1-cycle latency: addresses 0,4,8,… issued every 2 cycles. `if_pc`/`if_inst` follow with `if_valid` pulses; the first `if_valid` appears 2 cycles after the first request.
- `stall`=1 held 5 cycles while a response arrives: the response is parked in HOLD and no new request is issued. `if_*` are unchanged throughout. After stall drops, the parked word appears next cycle, then a request to pc+4 follows.
- `PCSel`=1 with target 32'h0000_0103 while in WAIT: the next response is discarded and never reaches `if_valid`. The next request address is 32'h0000_0100.
- Redirect in the same cycle as `imem_rsp_valid`: that word is dropped, and the next request goes to the target with no DROP cycle.
- `imem_req_ready` low for 3 cycles: `imem_req_valid` and address stay stable, and no duplicate request is issued.
- PC 32'hFFFF_FFFC fetched: the next request address is 32'h0000_0000. Asserting `rst_n`=0 mid-WAIT returns all outputs to reset values at the next edge.
